// File: rtl/divmod_unit_pkg.sv
// Shared types for the multi-cycle divide/modulo engine.
// The state encoding is exported so checkers and the CPU can observe the engine.
package divmod_unit_pkg;

  localparam int DIVMOD_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/divmod_unit.sv
// Restoring radix-2 integer divide/modulo, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero short-circuits to DONE; -2^(W-1)/-1 wraps through the normal path.
module divmod_unit
  import divmod_unit_pkg::*;
#(
  parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_denom,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dz,
  output div_state_e       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshakes: a transfer happens on an edge where valid && ready; a command is
  // taken only in IDLE, and a result is held unchanged until out_ready is seen.

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d, denom_q, denom_d;
  logic             sgn_q, sgn_d, dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             out_valid_q, out_valid_d, out_dz_q, out_dz_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d, out_rem_q, out_rem_d;

  logic [WIDTH:0]   shifted, trial;
  logic             ge;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  // Partial remainder stays below the divisor, so the trial difference borrows
  // (top bit set) exactly when the shifted remainder is smaller than the divisor.
  always_comb begin
    shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    ge      = !trial[WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    denom_d     = denom_q;
    sgn_d       = sgn_q;
    dz_d        = dz_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid_q;
    out_dz_d    = out_dz_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    if (flush) begin
      state_d     = DIV_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (in_valid) begin
          num_d    = in_num;
          denom_d  = in_denom;
          sgn_d    = in_signed;
          dz_d     = (in_denom == '0);
          out_dz_d = 1'b0;
          state_d  = DIV_PREP;
        end
        DIV_PREP: if (dz_q) begin
          out_quot_d  = '1;
          out_rem_d   = num_q;
          out_dz_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DIV_DONE;
        end else begin
          quo_d   = abs_f(num_q, sgn_q);
          dvs_d   = abs_f(denom_q, sgn_q);
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          q_neg_d = sgn_q & (num_q[WIDTH-1] ^ denom_q[WIDTH-1]);
          r_neg_d = sgn_q & num_q[WIDTH-1];
          state_d = DIV_ITER;
        end
        DIV_ITER: begin
          rem_d = ge ? trial : shifted;
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          out_quot_d  = q_neg_q ? neg_f(quo_q) : quo_q;
          out_rem_d   = r_neg_q ? neg_f(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = DIV_DONE;
        end
        DIV_DONE: if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      num_q       <= '0;
      denom_q     <= '0;
      sgn_q       <= 1'b0;
      dz_q        <= 1'b0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_dz_q    <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      denom_q     <= denom_d;
      sgn_q       <= sgn_d;
      dz_q        <= dz_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
      out_dz_q    <= out_dz_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
    end
  end

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = out_valid_q;
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_dz    = out_dz_q;
  assign dbg_state = state_q;

endmodule
